fifo_rd_stream: RTL and testbench

// - Read-side consumer of the async FIFO in the rclk domain: drives rinc from rempty, captures RAM read

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_rd_skid_buf.sv | 54 +++++
 rtl/fifo_rd_stream.sv | 105 ++++++++++
 tb/tb_fifo_rd_stream.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and helpers for the async FIFO read side.
// Imported by fifo_rd_stream and fifo_rd_skid_buf.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } rd_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// fifo_rd_skid_buf: circular output buffer with push/pop/occupancy.
// Indices wrap at DEPTH, so non-power-of-2 depths are fine.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 2,
  localparam int OW = clog2(DEPTH + 1),
  localparam int IW = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [OW-1:0]         occ
);

  localparam logic [IW-1:0] LAST  = IW'(DEPTH - 1);
  localparam logic [OW-1:0] FULLV = OW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;
  logic                  do_pop;

  assign do_pop = pop && (occ != '0);
  assign head   = mem[rd_idx];

  // Storage, wrapping indices and occupancy; pop on empty is ignored
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        assert (occ != FULLV);
        mem[wr_idx] <= wdata;
        wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
      end
      if (do_pop)
        rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
      unique case ({push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: credit-based FIFO read consumer to valid/ready stream.
// Optional FIFO_RD_STATS_EN adds stat_words/stat_stall counters.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  output logic                  rinc,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [15:0]           stat_words,
  output logic [15:0]           stat_stall
`endif
);

  localparam int OW = clog2(BUF_DEPTH + 1);
  localparam int CW = clog2(BUF_DEPTH + RD_LATENCY + 2);

  logic [RD_LATENCY-1:0] vld_pipe;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         used;
  logic [OW-1:0]         occ;
  logic                  push;
  logic                  pop;
  rd_state_t             state;

  assign push    = vld_pipe[RD_LATENCY-1];
  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;

  // Count reads issued but not yet written into the buffer
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      inflight = inflight + CW'(vld_pipe[i]);
  end

  // Issue a read only if a buffer slot is reserved for its data
  always_comb begin
    used = inflight + CW'(occ) - CW'(pop);
    rinc = rrst_n && !rempty && (used < CW'(BUF_DEPTH));
  end

  // Track accepted reads until their data arrives
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) vld_pipe <= '0;
    else         vld_pipe <= (vld_pipe << 1) | RD_LATENCY'(rinc);
  end

  // Observability state; outputs come from the counters
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: if (rinc) state <= FILL;
        FILL:
          if (CW'(inflight) + CW'(occ) == CW'(BUF_DEPTH))
            state <= FULL;
          else if (occ == '0 && inflight == '0 && !rinc)
            state <= IDLE;
        FULL: if (pop) state <= FILL;
        default: state <= IDLE;
      endcase
    end
  end

  fifo_rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (BUF_DEPTH)
  ) u_buf (
    .rclk  (rclk),
    .rrst_n(rrst_n),
    .push  (push),
    .wdata (rdata),
    .pop   (pop),
    .head  (m_data),
    .occ   (occ)
  );

`ifdef FIFO_RD_STATS_EN
  // Saturating delivery and stall counters
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      stat_words <= '0;
      stat_stall <= '0;
    end else begin
      if (pop && stat_words != 16'hFFFF)
        stat_words <= stat_words + 16'd1;
      if (m_valid && !m_ready && stat_stall != 16'hFFFF)
        stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench for two fifo_rd_stream builds.
// dut0: RD_LATENCY=1/BUF_DEPTH=2, dut1: RD_LATENCY=3/BUF_DEPTH=2.
module tb_fifo_rd_stream;

  localparam int DEP = 2;

  logic       clk = 1'b0;
  logic       rrst_n = 1'b0;
  logic       rempty0 = 1'b1, rempty1 = 1'b1;
  logic       m_ready0 = 1'b0, m_ready1 = 1'b0;
  logic [7:0] rdata0 = '0, rdata1 = '0;
  logic       rinc0, rinc1, m_valid0, m_valid1;
  logic [7:0] m_data0, m_data1;
`ifdef FIFO_RD_STATS_EN
  logic [15:0] sw0, ss0, sw1, ss1;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int         cnt[2];
  logic       acc[2];
  logic [7:0] accd[2];
  logic       pv[2][3];
  logic [7:0] pd[2][3];
  int         pops[2];
  int         stalls[2];
  int         first_rinc[2];
  int         first_val[2];

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .DATA_WIDTH(8), .RD_LATENCY(1), .BUF_DEPTH(DEP)
  ) dut0 (
    .rclk(clk), .rrst_n(rrst_n), .rempty(rempty0),
    .rinc(rinc0), .rdata(rdata0), .m_valid(m_valid0),
    .m_data(m_data0), .m_ready(m_ready0)
`ifdef FIFO_RD_STATS_EN
    , .stat_words(sw0), .stat_stall(ss0)
`endif
  );

  fifo_rd_stream #(
    .DATA_WIDTH(8), .RD_LATENCY(3), .BUF_DEPTH(DEP)
  ) dut1 (
    .rclk(clk), .rrst_n(rrst_n), .rempty(rempty1),
    .rinc(rinc1), .rdata(rdata1), .m_valid(m_valid1),
    .m_data(m_data1), .m_ready(m_ready1)
`ifdef FIFO_RD_STATS_EN
    , .stat_words(sw1), .stat_stall(ss1)
`endif
  );

  task automatic clear_model();
    exp0.delete();
    exp1.delete();
    for (int k = 0; k < 2; k++) begin
      acc[k] = 1'b0;
      accd[k] = '0;
      pops[k] = 0;
      stalls[k] = 0;
      for (int i = 0; i < 3; i++) begin
        pv[k][i] = 1'b0;
        pd[k][i] = '0;
      end
    end
  endtask

  // One rclk cycle: RAM model, drive, sample, scoreboard
  task automatic cycle(input logic e0, input logic r0,
                       input logic e1, input logic r1);
    logic [1:0] ri, mv, mr, em;
    logic [7:0] md[2];
    logic [7:0] w;
    int sz;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      for (int i = 2; i > 0; i--) begin
        pv[k][i] = pv[k][i-1];
        pd[k][i] = pd[k][i-1];
      end
      pv[k][0] = acc[k];
      pd[k][0] = accd[k];
    end
    rdata0 = pv[0][0] ? pd[0][0] : 8'($urandom);
    rdata1 = pv[1][2] ? pd[1][2] : 8'($urandom);
    rempty0 = e0; m_ready0 = r0;
    rempty1 = e1; m_ready1 = r1;
    #1;
    ri = {rinc1, rinc0};
    mv = {m_valid1, m_valid0};
    mr = {r1, r0};
    em = {e1, e0};
    md[0] = m_data0;
    md[1] = m_data1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (ri[k] && em[k]) begin
        bad++;
        $display("FAIL rinc_while_empty dut%0d: rinc=%b required 0",
                 k, ri[k]);
      end
      acc[k] = ri[k] && !em[k];
      accd[k] = 8'(cnt[k]);
      if (acc[k]) begin
        cnt[k]++;
        if (k == 0) exp0.push_back(accd[k]);
        else        exp1.push_back(accd[k]);
        if (first_rinc[k] < 0) first_rinc[k] = cyc;
      end
      if (mv[k] && first_val[k] < 0) first_val[k] = cyc;
      if (mv[k] && !mr[k]) stalls[k]++;
      if (mv[k] && mr[k]) begin
        pops[k]++;
        total++;
        sz = (k == 0) ? exp0.size() : exp1.size();
        if (sz == 0) begin
          bad++;
          $display("FAIL extra_word dut%0d: got %h, required none",
                   k, md[k]);
        end else begin
          if (k == 0) w = exp0.pop_front();
          else        w = exp1.pop_front();
          if (md[k] !== w) begin
            bad++;
            $display("FAIL order dut%0d: m_data=%h required %h",
                     k, md[k], w);
          end
        end
      end
      sz = (k == 0) ? exp0.size() : exp1.size();
      total++;
      if (sz > DEP) begin
        bad++;
        $display("FAIL credit dut%0d: outstanding=%0d required <=%0d",
                 k, sz, DEP);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && n < 40) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      n++;
    end
    total++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: left=%0d/%0d required 0/0",
               exp0.size(), exp1.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rrst_n = 1'b0;
    rempty0 = 1'b0; rempty1 = 1'b0;
    m_ready0 = 1'b1; m_ready1 = 1'b1;
    clear_model();
    #1;
    total++;
    if (rinc0 !== 1'b0 || rinc1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_rinc: %b%b required 00", rinc1, rinc0);
    end
    total++;
    if (m_valid0 !== 1'b0 || m_valid1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: %b%b required 00", m_valid1, m_valid0);
    end
    total++;
    if (m_data0 !== 8'h00 || m_data1 !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: %h/%h required 00/00", m_data0, m_data1);
    end
`ifdef FIFO_RD_STATS_EN
    total++;
    if (sw0 !== 16'd0 || ss0 !== 16'd0 || sw1 !== 16'd0 || ss1 !== 16'd0) begin
      bad++;
      $display("FAIL reset_stats: %h %h %h %h required 0",
               sw0, ss0, sw1, ss1);
    end
`endif
    rempty0 = 1'b1; rempty1 = 1'b1;
    m_ready0 = 1'b0; m_ready1 = 1'b0;
    @(posedge clk);
    #1 rrst_n = 1'b1;
  endtask

  task automatic test_stream();
    int s, p0, p1;
    first_rinc[0] = -1; first_rinc[1] = -1;
    first_val[0] = -1; first_val[1] = -1;
    s = cyc + 1;
    repeat (10) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    p0 = pops[0];
    p1 = pops[1];
    repeat (12) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    total++;
    if (first_rinc[0] != s || first_rinc[1] != s) begin
      bad++;
      $display("FAIL first_rinc: %0d/%0d required %0d",
               first_rinc[0], first_rinc[1], s);
    end
    total++;
    if (first_val[0] != s + 2) begin
      bad++;
      $display("FAIL latency_l1: valid at %0d required %0d",
               first_val[0], s + 2);
    end
    total++;
    if (first_val[1] != s + 4) begin
      bad++;
      $display("FAIL latency_l3: valid at %0d required %0d",
               first_val[1], s + 4);
    end
    total++;
    if (pops[0] - p0 != 12) begin
      bad++;
      $display("FAIL rate_l1: %0d words required 12", pops[0] - p0);
    end
    total++;
    if (pops[1] - p1 != 6) begin
      bad++;
      $display("FAIL rate_l3: %0d words required 6", pops[1] - p1);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int c0, c1;
    c0 = cnt[0];
    c1 = cnt[1];
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (cnt[0] - c0 != DEP || cnt[1] - c1 != DEP) begin
      bad++;
      $display("FAIL bp_reads: %0d/%0d required %0d",
               cnt[0] - c0, cnt[1] - c1, DEP);
    end
    total++;
    if (m_valid0 !== 1'b1 || m_valid1 !== 1'b1 ||
        rinc0 !== 1'b0 || rinc1 !== 1'b0) begin
      bad++;
      $display("FAIL bp_hold: valid=%b%b rinc=%b%b required 11 00",
               m_valid1, m_valid0, rinc1, rinc0);
    end
    drain();
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 60; i++)
      cycle(1'(i % 2), 1'($urandom_range(0, 1)),
            1'((i + 1) % 2), 1'($urandom_range(0, 1)));
    drain();
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    total++;
    if (m_valid0 !== 1'b1 || exp0.size() != 2 || exp1.size() != 2) begin
      bad++;
      $display("FAIL mid_setup: valid=%b out=%0d/%0d required 1 2/2",
               m_valid0, exp0.size(), exp1.size());
    end
    test_reset();
    repeat (8) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    drain();
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats();
    int es0, es1;
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (70000) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    es0 = (stalls[0] > 65535) ? 65535 : stalls[0];
    es1 = (stalls[1] > 65535) ? 65535 : stalls[1];
    total++;
    if (ss0 !== 16'hFFFF || ss1 !== 16'hFFFF ||
        ss0 !== 16'(es0) || ss1 !== 16'(es1)) begin
      bad++;
      $display("FAIL stat_stall: %h/%h required ffff", ss0, ss1);
    end
    drain();
    total++;
    if (sw0 !== 16'(pops[0]) || sw1 !== 16'(pops[1])) begin
      bad++;
      $display("FAIL stat_words: %0d/%0d required %0d/%0d",
               sw0, sw1, pops[0], pops[1]);
    end
  endtask
`endif

  initial begin
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0;
      first_rinc[k] = -1;
      first_val[k] = -1;
    end
    clear_model();
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_reset_mid();
`ifdef FIFO_RD_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
